// File: rtl/capture_pkg.sv
// capture_pkg: shared widths, buffer depth and FSM encoding for the sample capture block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package capture_pkg;

  // Default widths: 14-bit offset-binary samples (same format as the DAC values),
  // a 1024-entry frame buffer and an 8-bit decimation divider.
  localparam int CAP_DATA_W = 14;
  localparam int CAP_ADDR_W = 10;
  localparam int CAP_DIV_W  = 8;
  localparam int CAP_DEPTH  = 1024;

  // State codes kept as plain constants so legacy code and waveform decoders
  // that know the raw 2-bit values keep working.
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = S_IDLE,
    ARMED   = S_ARMED,
    CAPTURE = S_CAPTURE,
    DONE    = S_DONE
  } cap_state_e;

endpackage

// File: rtl/sample_capture_if.sv
// sample_capture_if: sample stream, capture control, status and buffer read port.
// Latency: n/a (wiring only); rd_data is registered inside the capture block.
// Backpressure: none; the sample stream is a plain valid-qualified bus.
// Signals:
//   sample_in/sample_en           converter sample and its valid qualifier
//   arm/trig_enable/force_trig    capture start, trigger mode, manual trigger
//   trig_level/time_division      threshold and keep-1-of-(N+1) divider
//   rd_addr/rd_data               random-access buffer read
//   busy/done/done_pulse          capture status
// Modports: master drives the stream and control (ADC side / sweep logic),
// slave is the capture block.
interface sample_capture_if
  import capture_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int ADDR_W = CAP_ADDR_W,
  parameter int DIV_W  = CAP_DIV_W
);

  logic [DATA_W-1:0] sample_in;
  logic              sample_en;
  logic              arm;
  logic              trig_enable;
  logic              force_trig;
  logic [DATA_W-1:0] trig_level;
  logic [DIV_W-1:0]  time_division;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              done_pulse;

  modport master (
    output sample_in,
    output sample_en,
    output arm,
    output trig_enable,
    output force_trig,
    output trig_level,
    output time_division,
    output rd_addr,
    input  rd_data,
    input  busy,
    input  done,
    input  done_pulse
  );

  modport slave (
    input  sample_in,
    input  sample_en,
    input  arm,
    input  trig_enable,
    input  force_trig,
    input  trig_level,
    input  time_division,
    input  rd_addr,
    output rd_data,
    output busy,
    output done,
    output done_pulse
  );

endinterface

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port frame buffer, one write port and one registered read port.
// Latency: write lands on the clock edge; rd_data = mem[rd_addr] one cycle later.
// Backpressure: none; both ports accept an access every cycle.
// Ports:
//   clk_dac, reset      clock; reset clears only the read register, never the array
//   wr_en/wr_addr/wr_data   write port
//   rd_addr/rd_data     registered read port, read-before-write on an address collision
module capture_ram #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 10
) (
  input  logic              clk_dac,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // No reset on the array so it maps onto block RAM; captured data survives
  // a reset and stays readable.
  always_ff @(posedge clk_dac) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read samples the array before this edge's write takes effect, which
  // gives old data on a same-address collision. The synchronous clear maps
  // onto the block RAM output-register reset.
  always_ff @(posedge clk_dac) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sample_capture.sv
// sample_capture: records one 1024-sample frame after arm (immediately or on a rising level
//   crossing), keeping 1 of every time_division+1 valid samples; buffer read back at random.
// Latency: accepted sample is in the buffer after its edge; rd_data lags rd_addr by one cycle.
// Backpressure: none; valid samples arriving outside a capture only feed the trigger history.
// Ports:
//   clk_dac  sample clock, rising edge
//   reset    synchronous, active-high; buffer contents are kept
//   bus      sample stream, control, status and read port (sample_capture_if.slave)
module sample_capture
  import capture_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int ADDR_W = CAP_ADDR_W,
  parameter int DIV_W  = CAP_DIV_W
) (
  input  logic            clk_dac,
  input  logic            reset,
  sample_capture_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  cap_state_e        state;
  logic [ADDR_W-1:0] wr_addr;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_max;
  logic [DATA_W-1:0] level_q;
  logic [DATA_W-1:0] prev_sample;
  logic              prev_valid;
  logic              done_pulse_q;
  logic [DATA_W-1:0] ram_rd_data;

  logic crossing;
  logic trig_hit;
  logic cap_write;
  logic wr_en;
  logic frame_end;

  // Modulo-(lim+1) step of the decimation counter.
  function automatic logic [DIV_W-1:0] div_next(input logic [DIV_W-1:0] cnt,
                                                input logic [DIV_W-1:0] lim);
    return (cnt == lim) ? '0 : cnt + DIV_W'(1);
  endfunction

  always_comb begin
    // Rising crossing only: the previous sample must be strictly below the
    // level, so falling edges and flat runs at the level never fire.
    crossing  = prev_valid && (prev_sample < level_q) && (bus.sample_in >= level_q);
    trig_hit  = (state == ARMED) && bus.sample_en && crossing;
    cap_write = (state == CAPTURE) && bus.sample_en && (div_cnt == '0);
    // The triggering sample itself is the first word of the frame; wr_addr is
    // still 0 while ARMED, so it lands at address 0.
    wr_en     = trig_hit || cap_write;
    frame_end = cap_write && (wr_addr == ADDR_LAST);
  end

  always_ff @(posedge clk_dac) begin
    if (reset) begin
      state        <= IDLE;
      wr_addr      <= '0;
      div_cnt      <= '0;
      div_max      <= '0;
      level_q      <= '0;
      prev_sample  <= '0;
      prev_valid   <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      done_pulse_q <= 1'b0;

      // Trigger history tracks every valid sample in every state so a crossing
      // can be seen on the very first samples after ARMED is entered.
      if (bus.sample_en) begin
        prev_sample <= bus.sample_in;
        prev_valid  <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (bus.arm) begin
            level_q    <= bus.trig_level;
            div_max    <= bus.time_division;
            wr_addr    <= '0;
            div_cnt    <= '0;
            // History from before the arm must not complete a crossing; this
            // overrides the prev_valid set above.
            prev_valid <= 1'b0;
            state      <= bus.trig_enable ? ARMED : CAPTURE;
          end
        end

        ARMED: begin
          if (trig_hit) begin
            wr_addr <= wr_addr + ADDR_W'(1);
            div_cnt <= div_next(div_cnt, div_max);
            state   <= CAPTURE;
          end else if (bus.force_trig) begin
            // No write here: the next valid sample becomes word 0 because
            // div_cnt is still 0.
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (bus.sample_en) begin
            div_cnt <= div_next(div_cnt, div_max);
            if (cap_write) begin
              wr_addr <= wr_addr + ADDR_W'(1);
            end
            if (frame_end) begin
              state        <= DONE;
              done_pulse_q <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_dac (clk_dac),
    .reset   (reset),
    .wr_en   (wr_en && !reset),
    .wr_addr (wr_addr),
    .wr_data (bus.sample_in),
    .rd_addr (bus.rd_addr),
    .rd_data (ram_rd_data)
  );

  // Status is decoded straight from the state so busy falls on the same edge
  // that done rises.
  assign bus.busy       = (state == ARMED) || (state == CAPTURE);
  assign bus.done       = (state == DONE);
  assign bus.done_pulse = done_pulse_q;
  assign bus.rd_data    = ram_rd_data;

endmodule

// File: tb/tb_sample_capture.sv
// tb_sample_capture: randomized frame captures checked against a sample-list reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sample_capture;
  import capture_pkg::*;

  localparam int DW = CAP_DATA_W;
  localparam int AW = CAP_ADDR_W;
  localparam int DV = CAP_DIV_W;
  localparam int NB = CAP_DEPTH;

  logic clk_dac = 1'b0;
  logic reset;
  always #5 clk_dac = ~clk_dac;

  sample_capture_if #(.DATA_W(DW), .ADDR_W(AW), .DIV_W(DV)) bus ();

  sample_capture #(.DATA_W(DW), .ADDR_W(AW), .DIV_W(DV)) dut (
    .clk_dac (clk_dac),
    .reset   (reset),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] seen [$];      // valid samples presented since the last arm
  logic [DW-1:0] exp_buf [NB];  // what the buffer should hold
  logic [DW-1:0] got [NB];
  int done_cyc, done_valid, pulse_count, seq_err, tail_err;

  task automatic clk1();
    @(posedge clk_dac);
    #1;
  endtask

  task automatic present(input bit en, input logic [DW-1:0] v);
    bus.sample_en = en;
    bus.sample_in = v;
    clk1();
    if (en) seen.push_back(v);
    bus.sample_en = 1'b0;
  endtask

  task automatic do_arm(input bit te, input logic [DW-1:0] lvl, input logic [DV-1:0] td);
    bus.arm = 1'b1; bus.trig_enable = te; bus.trig_level = lvl; bus.time_division = td;
    bus.sample_en = 1'b0;
    clk1();
    bus.arm = 1'b0;
    bus.trig_level = DW'($urandom);
    bus.time_division = DV'($urandom);
    seen.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; clk1(); reset = 1'b0;
  endtask

  task automatic read1(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bus.rd_addr = a; bus.sample_en = 1'b0;
    clk1();
    d = bus.rd_data;
  endtask

  task automatic read_all();
    for (int a = 0; a < NB; a++) read1(AW'(a), got[a]);
  endtask

  // mode 0: ramp value = base + number of valid samples since arm; mode 1: random.
  // gap 1: always valid, 3: every third cycle, 0: random ~75%.
  task automatic run_frame(input bit arm_it, input bit te, input logic [DW-1:0] lvl,
                           input logic [DV-1:0] td, input int mode, input int base,
                           input int gap, input int max_cyc, input int stop_n);
    int c;
    bit en, prev_busy;
    logic [DW-1:0] v;
    done_cyc = -1; done_valid = -1; pulse_count = 0; seq_err = 0; tail_err = 0;
    if (arm_it) begin
      bus.arm = 1'b1; bus.trig_enable = te; bus.trig_level = lvl; bus.time_division = td;
      bus.sample_en = (mode == 0); bus.sample_in = DW'(base - 1);
      clk1();
      bus.arm = 1'b0;
      bus.trig_level = DW'($urandom);
      bus.time_division = DV'($urandom);
      seen.delete();
    end
    c = 0;
    while (done_cyc < 0 && c < max_cyc && !(stop_n > 0 && seen.size() >= stop_n)) begin
      c++;
      if (gap == 1) en = 1'b1;
      else if (gap == 3) en = (c % 3 == 0);
      else en = ($urandom_range(0, 3) != 0);
      v = (mode == 0) ? DW'(base + seen.size()) : DW'($urandom);
      prev_busy = bus.busy;
      present(en, v);
      if (bus.busy && bus.done) seq_err++;
      if (bus.done_pulse) pulse_count++;
      if (bus.done_pulse && !bus.done) seq_err++;
      if (bus.done && done_cyc < 0) begin
        done_cyc = c;
        done_valid = seen.size();
        if (!prev_busy || !bus.done_pulse) seq_err++;
      end
    end
    if (done_cyc >= 0 && stop_n == 0) begin
      repeat (4) begin
        present($urandom_range(0, 1) == 1, DW'($urandom));
        if (bus.done_pulse) pulse_count++;
        if (!bus.done || bus.busy) tail_err++;
      end
    end
  endtask

  // Reference: the frame is the trigger sample (or the first sample after arm)
  // followed by every (td+1)-th valid sample after it.
  task automatic model_frame(input bit te, input logic [DW-1:0] lvl, input logic [DV-1:0] td,
                             output int need);
    int s, idx;
    s = te ? -1 : 0;
    if (te) begin
      for (int i = 1; i < seen.size(); i++)
        if (s < 0 && seen[i-1] < lvl && seen[i] >= lvl) s = i;
    end
    need = -1;
    if (s >= 0) begin
      for (int k = 0; k < NB; k++) begin
        idx = s + k * (int'(td) + 1);
        if (idx < seen.size()) exp_buf[k] = seen[idx];
      end
      need = s + (NB - 1) * (int'(td) + 1) + 1;
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    // Stimulus bookkeeping only: kept out of the comparison path on purpose.
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.sample_en = 1'b1; bus.sample_in = DW'($urandom); bus.arm = 1'b1; bus.force_trig = 1'b1;
    bus.rd_addr = AW'($urandom);
    repeat (3) clk1();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    total++; if (bus.done_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got %b want 0", bus.done_pulse); end
    total++; if (bus.rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got %0d want 0", bus.rd_data); end
    reset = 1'b0; bus.arm = 1'b0; bus.force_trig = 1'b0; bus.sample_en = 1'b0;
    clk1();
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL reset_idle got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_free_run();
    int need;
    run_frame(1'b1, 1'b0, '0, '0, 0, 100, 1, 1200, 0);
    model_frame(1'b0, '0, '0, need);
    total++; if (done_cyc !== 1024) begin bad++; $display("FAIL free_run_done_cycle got %0d want 1024", done_cyc); end
    total++; if (done_valid !== need) begin bad++; $display("FAIL free_run_valid got %0d want %0d", done_valid, need); end
    total++; if (pulse_count !== 1) begin bad++; $display("FAIL free_run_pulses got %0d want 1", pulse_count); end
    total++; if (seq_err !== 0) begin bad++; $display("FAIL free_run_busy_done got %0d errors want 0", seq_err); end
    total++; if (tail_err !== 0) begin bad++; $display("FAIL free_run_done_hold got %0d errors want 0", tail_err); end
    read_all();
    for (int k = 0; k < NB; k++) begin
      total++;
      if (got[k] !== exp_buf[k]) begin bad++; $display("FAIL free_run_buf[%0d] got %0d want %0d", k, got[k], exp_buf[k]); end
    end
  endtask

  task automatic test_trigger();
    int need;
    logic [DW-1:0] d, x;
    logic [DW-1:0] ramp [5];
    ramp[0] = 14'd8000; ramp[1] = 14'd8100; ramp[2] = 14'd8191; ramp[3] = 14'd8192; ramp[4] = 14'd8300;
    do_arm(1'b1, 14'd8192, '0);
    for (int i = 0; i < 5; i++) present(1'b1, ramp[i]);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL trig_busy got %b want 1", bus.busy); end
    read1('0, d);
    total++; if (d !== 14'd8192) begin bad++; $display("FAIL trig_buf0 got %0d want 8192", d); end
    read1(AW'(1), d);
    total++; if (d !== 14'd8300) begin bad++; $display("FAIL trig_buf1 got %0d want 8300", d); end
    run_frame(1'b0, 1'b1, 14'd8192, '0, 1, 0, 1, 1200, 0);
    model_frame(1'b1, 14'd8192, '0, need);
    total++; if (done_valid !== need) begin bad++; $display("FAIL trig_valid got %0d want %0d", done_valid, need); end
    total++; if (pulse_count !== 1) begin bad++; $display("FAIL trig_pulses got %0d want 1", pulse_count); end
    read_all();
    for (int k = 0; k < NB; k++) begin
      total++;
      if (got[k] !== exp_buf[k]) begin bad++; $display("FAIL trig_buf[%0d] got %0d want %0d", k, got[k], exp_buf[k]); end
    end
    // Falling edge and equal samples must not fire; force_trig then starts at word 0.
    do_arm(1'b1, 14'd8192, '0);
    present(1'b1, 14'd8300); present(1'b1, 14'd8192); present(1'b1, 14'd8192); present(1'b0, '0);
    total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++; $display("FAIL notrig_state got busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    bus.force_trig = 1'b1; clk1(); bus.force_trig = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL force_busy got %b want 1", bus.busy); end
    x = DW'($urandom);
    present(1'b1, x);
    read1('0, d);
    total++; if (d !== x) begin bad++; $display("FAIL force_buf0 got %0d want %0d", d, x); end
    read1(AW'(1), d);
    total++; if (d !== exp_buf[1]) begin bad++; $display("FAIL notrig_buf1 got %0d want %0d", d, exp_buf[1]); end
    exp_buf[0] = x;
    do_reset();
  endtask

  task automatic test_decimation();
    int need;
    run_frame(1'b1, 1'b1, 14'd50, 8'd3, 0, 0, 1, 5000, 0);
    model_frame(1'b1, 14'd50, 8'd3, need);
    total++; if (done_valid !== need) begin bad++; $display("FAIL decim_valid got %0d want %0d", done_valid, need); end
    total++; if (pulse_count !== 1) begin bad++; $display("FAIL decim_pulses got %0d want 1", pulse_count); end
    total++; if (seq_err !== 0) begin bad++; $display("FAIL decim_busy_done got %0d errors want 0", seq_err); end
    read_all();
    for (int k = 0; k < NB; k++) begin
      total++;
      if (got[k] !== exp_buf[k]) begin bad++; $display("FAIL decim_buf[%0d] got %0d want %0d", k, got[k], exp_buf[k]); end
    end
  endtask

  task automatic test_gapped();
    int need;
    run_frame(1'b1, 1'b0, '0, '0, 0, $urandom_range(0, 15000), 3, 3300, 0);
    model_frame(1'b0, '0, '0, need);
    total++; if (done_cyc !== 3072) begin bad++; $display("FAIL gap_done_cycle got %0d want 3072", done_cyc); end
    total++; if (done_valid !== need) begin bad++; $display("FAIL gap_valid got %0d want %0d", done_valid, need); end
    total++; if (pulse_count !== 1) begin bad++; $display("FAIL gap_pulses got %0d want 1", pulse_count); end
    read_all();
    for (int k = 0; k < NB; k++) begin
      total++;
      if (got[k] !== exp_buf[k]) begin bad++; $display("FAIL gap_buf[%0d] got %0d want %0d", k, got[k], exp_buf[k]); end
    end
  endtask

  task automatic test_random_frame();
    int need;
    logic [DV-1:0] td;
    logic [DW-1:0] lvl;
    td = DV'($urandom_range(0, 2));
    lvl = DW'($urandom_range(1000, 15000));
    run_frame(1'b1, 1'b1, lvl, td, 1, 0, 0, 8000, 0);
    model_frame(1'b1, lvl, td, need);
    total++; if (done_valid !== need) begin bad++; $display("FAIL rand_valid got %0d want %0d", done_valid, need); end
    total++; if (tail_err !== 0) begin bad++; $display("FAIL rand_done_hold got %0d errors want 0", tail_err); end
    read_all();
    for (int k = 0; k < NB; k++) begin
      total++;
      if (got[k] !== exp_buf[k]) begin bad++; $display("FAIL rand_buf[%0d] got %0d want %0d", k, got[k], exp_buf[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int need;
    run_frame(1'b1, 1'b0, '0, '0, 0, $urandom_range(0, 15000), 1, 600, 500);
    bus.rd_addr = AW'(3);
    bus.sample_en = 1'b1; bus.sample_in = DW'($urandom);
    reset = 1'b1; clk1(); reset = 1'b0;
    bus.sample_en = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rmid_done got %b want 0", bus.done); end
    total++; if (bus.rd_data !== '0) begin bad++; $display("FAIL rmid_rd_data got %0d want 0", bus.rd_data); end
    clk1();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_idle got busy=%b want 0", bus.busy); end
    model_frame(1'b0, '0, '0, need);  // first 500 words new, the rest from the previous frame
    read_all();
    for (int k = 0; k < NB; k++) begin
      total++;
      if (got[k] !== exp_buf[k]) begin bad++; $display("FAIL rmid_buf[%0d] got %0d want %0d", k, got[k], exp_buf[k]); end
    end
    run_frame(1'b1, 1'b0, '0, '0, 1, 0, 1, 1200, 0);
    model_frame(1'b0, '0, '0, need);
    total++; if (done_cyc !== 1024) begin bad++; $display("FAIL rearm_done_cycle got %0d want 1024", done_cyc); end
    read_all();
    for (int k = 0; k < NB; k++) begin
      total++;
      if (got[k] !== exp_buf[k]) begin bad++; $display("FAIL rearm_buf[%0d] got %0d want %0d", k, got[k], exp_buf[k]); end
    end
  endtask

  task automatic test_controls();
    int need;
    logic [AW-1:0] a, pa;
    do_arm(1'b0, '0, '0);
    for (int i = 0; i < 10; i++) present(1'b1, DW'(seen.size()));
    bus.arm = 1'b1; bus.trig_enable = 1'b1; bus.time_division = 8'd5; bus.trig_level = DW'($urandom);
    present(1'b1, DW'(seen.size()));
    bus.arm = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL armcap_busy got %b want 1", bus.busy); end
    run_frame(1'b0, 1'b0, '0, '0, 0, 0, 1, 1200, 0);
    model_frame(1'b0, '0, '0, need);
    total++; if (done_valid !== need) begin bad++; $display("FAIL armcap_valid got %0d want %0d", done_valid, need); end
    read_all();
    for (int k = 0; k < NB; k++) begin
      total++;
      if (got[k] !== exp_buf[k]) begin bad++; $display("FAIL armcap_buf[%0d] got %0d want %0d", k, got[k], exp_buf[k]); end
    end
    // arm while DONE restarts and clears done on the next edge.
    bus.arm = 1'b1; bus.trig_enable = 1'b1; bus.trig_level = DW'($urandom); bus.sample_en = 1'b0;
    clk1();
    bus.arm = 1'b0;
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL armdone got done=%b busy=%b want 0 1", bus.done, bus.busy);
    end
    do_reset();
    // Read lag: rd_data keeps the previous address until the next edge.
    pa = AW'($urandom);
    read1(pa, got[0]);
    for (int i = 0; i < 20; i++) begin
      a = AW'($urandom);
      bus.rd_addr = a; bus.sample_en = ($urandom_range(0, 1) == 1); bus.sample_in = DW'($urandom);
      #1;
      total++;
      if (bus.rd_data !== exp_buf[pa]) begin bad++; $display("FAIL rdlag_hold[%0d] got %0d want %0d", pa, bus.rd_data, exp_buf[pa]); end
      clk1();
      total++;
      if (bus.rd_data !== exp_buf[a]) begin bad++; $display("FAIL rdlag_new[%0d] got %0d want %0d", a, bus.rd_data, exp_buf[a]); end
      pa = a;
    end
    bus.sample_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.sample_in = '0; bus.sample_en = 1'b0; bus.arm = 1'b0; bus.trig_enable = 1'b0;
    bus.force_trig = 1'b0; bus.trig_level = '0; bus.time_division = '0; bus.rd_addr = '0;
    test_reset();
    test_free_run();
    test_trigger();
    test_decimation();
    test_gapped();
    test_random_frame();
    test_reset_mid();
    test_controls();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
